// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

  localparam int unsigned REG_W = 5;

  // A writing, nonzero destination that matches a source register.
  function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic we,
                                   input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forward select for one E-stage source register; M beats W.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] m_rd,
  input  logic             m_reg_write,
  input  logic [REG_W-1:0] w_rd,
  input  logic             w_reg_write,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_NONE;
    if (reg_hit(m_rd, m_reg_write, rs)) sel = FWD_M;
    else if (reg_hit(w_rd, w_reg_write, rs)) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / memory-wait stalls and flushes.
// Define HAZARD_CTRL_FWD_EN to enable operand forwarding; otherwise RAW hazards stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       e_rd,
  input  logic             e_reg_write,
  input  logic             e_mem_read,
  input  logic [4:0]       m_rd,
  input  logic             m_reg_write,
  input  logic [4:0]       w_rd,
  input  logic             w_reg_write,
  input  logic             e_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             f_stall,
  output logic             stall,
  output logic             e_stall,
  output logic             m_stall,
  output logic             flush,
  output logic             e_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_hold;
  logic              load_use;
  fwd_sel_t          fwd_a_sel, fwd_b_sel;

  assign mem_hold = dmem_req & ~dmem_ready;

`ifdef HAZARD_CTRL_FWD_EN
  assign load_use = e_mem_read & (reg_hit(e_rd, e_reg_write, d_rs1) |
                                   reg_hit(e_rd, e_reg_write, d_rs2));

  fwd_unit u_fwd_a (
    .rs(de_rs1), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .sel(fwd_a_sel)
  );
  fwd_unit u_fwd_b (
    .rs(de_rs2), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .sel(fwd_b_sel)
  );
`else
  // No bypass paths: any pending E or M write to a D source must stall.
  assign load_use = reg_hit(e_rd, e_reg_write, d_rs1) | reg_hit(e_rd, e_reg_write, d_rs2) |
                    reg_hit(m_rd, m_reg_write, d_rs1) | reg_hit(m_rd, m_reg_write, d_rs2);
  assign fwd_a_sel = FWD_NONE;
  assign fwd_b_sel = FWD_NONE;

  logic unused_fwd;
  assign unused_fwd = ^{de_rs1, de_rs2, w_rd, w_reg_write, e_mem_read};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (f_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    f_stall      = 1'b0;
    stall        = 1'b0;
    e_stall      = 1'b0;
    m_stall      = 1'b0;
    flush        = 1'b0;
    e_flush      = 1'b0;
    fwd_a        = FWD_NONE;
    fwd_b        = FWD_NONE;
    mem_err      = (state == ERROR);

    case (state)
      RUN: begin
        if (mem_hold) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase

    // Memory hold masks branch/load-use; a frozen branch acts on release.
    if (!rst) begin
      fwd_a = fwd_a_sel;
      fwd_b = fwd_b_sel;
      if ((state == ERROR) || mem_hold) begin
        f_stall = 1'b1;
        stall   = 1'b1;
        e_stall = 1'b1;
        m_stall = 1'b1;
      end else if (e_branch_taken) begin
        flush   = 1'b1;
        e_flush = 1'b1;
      end else if (load_use) begin
        f_stall = 1'b1;
        stall   = 1'b1;
        e_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a monitor compares.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] d_rs1, d_rs2, de_rs1, de_rs2, e_rd, m_rd, w_rd;
  logic       e_reg_write, e_mem_read, m_reg_write, w_reg_write;
  logic       e_branch_taken, dmem_req, dmem_ready;
  logic       f_stall, stall, e_stall, m_stall, flush, e_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] stall_cycles;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .e_rd(e_rd), .e_reg_write(e_reg_write), .e_mem_read(e_mem_read),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .w_rd(w_rd), .w_reg_write(w_reg_write),
    .e_branch_taken(e_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .f_stall(f_stall), .stall(stall), .e_stall(e_stall), .m_stall(m_stall),
    .flush(flush), .e_flush(e_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       fs, st, es, ms, fl, ef, me;
    logic [1:0] fa, fb;
    logic [2:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] run_cnt = '0;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: the DUT is combinational per cycle, so every cycle presents an output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.name, "f_stall", int'(f_stall), int'(e.fs));
        chk(e.name, "stall", int'(stall), int'(e.st));
        chk(e.name, "e_stall", int'(e_stall), int'(e.es));
        chk(e.name, "m_stall", int'(m_stall), int'(e.ms));
        chk(e.name, "flush", int'(flush), int'(e.fl));
        chk(e.name, "e_flush", int'(e_flush), int'(e.ef));
        chk(e.name, "fwd_a", int'(fwd_a), int'(e.fa));
        chk(e.name, "fwd_b", int'(fwd_b), int'(e.fb));
        chk(e.name, "mem_err", int'(mem_err), int'(e.me));
        chk(e.name, "stall_cycles", int'(stall_cycles), int'(e.sc));
      end
    end
  end

  task automatic idle();
    rst = 1'b0;
    d_rs1 = '0; d_rs2 = '0; de_rs1 = '0; de_rs2 = '0;
    e_rd = '0; m_rd = '0; w_rd = '0;
    e_reg_write = 1'b0; e_mem_read = 1'b0; m_reg_write = 1'b0; w_reg_write = 1'b0;
    e_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Push the expectation for the inputs currently driven, then advance one cycle.
  task automatic step(input string nm, input bit fs, input bit st, input bit es, input bit ms,
                      input bit fl, input bit ef, input bit [1:0] fa, input bit [1:0] fb,
                      input bit me);
    exp_t e;
    e.name = nm; e.fs = fs; e.st = st; e.es = es; e.ms = ms;
    e.fl = fl; e.ef = ef; e.fa = fa; e.fb = fb; e.me = me; e.sc = run_cnt;
    q.push_back(e);
    if (rst) run_cnt = '0;
    else if (fs && run_cnt != 3'd7) run_cnt = run_cnt + 3'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset suppresses load-use and branch responses.
    rst = 1'b1; e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5;
    e_branch_taken = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle();
    step("idle", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    idle(); e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5;
    step("lu_rs1", 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    idle();
    step("lu_after", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(); e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0;
    step("lu_x0", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(); e_mem_read = 1'b1; e_reg_write = 1'b0; e_rd = 5'd5; d_rs2 = 5'd5;
    step("lu_nowrite", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(); e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd9; d_rs2 = 5'd9;
    step("lu_rs2", 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    idle(); e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd9; d_rs2 = 5'd9;
    e_branch_taken = 1'b1;
    step("br_over_lu", 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);

    idle(); m_rd = 5'd7; m_reg_write = 1'b1; w_rd = 5'd7; w_reg_write = 1'b1; de_rs2 = 5'd7;
    step("fwdb_m", 0, 0, 0, 0, 0, 0, 2'b00, FWD ? 2'b10 : 2'b00, 0);
    m_reg_write = 1'b0;
    step("fwdb_w", 0, 0, 0, 0, 0, 0, 2'b00, FWD ? 2'b01 : 2'b00, 0);
    idle(); m_rd = 5'd0; m_reg_write = 1'b1; w_rd = 5'd0; w_reg_write = 1'b1; de_rs2 = 5'd0;
    step("fwdb_x0", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(); m_rd = 5'd4; m_reg_write = 1'b1; w_rd = 5'd4; w_reg_write = 1'b1;
    de_rs1 = 5'd4; de_rs2 = 5'd6;
    step("fwda_m", 0, 0, 0, 0, 0, 0, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    idle(); m_rd = 5'd3; m_reg_write = 1'b1; w_rd = 5'd8; w_reg_write = 1'b1;
    de_rs1 = 5'd3; de_rs2 = 5'd8;
    step("fwd_both", 0, 0, 0, 0, 0, 0, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 0);

    idle(); m_rd = 5'd3; m_reg_write = 1'b1; d_rs2 = 5'd3;
    step("raw_m", !FWD, !FWD, 0, 0, 0, !FWD, 2'b00, 2'b00, 0);
    idle(); e_rd = 5'd12; e_reg_write = 1'b1; d_rs1 = 5'd12;
    step("raw_e_alu", !FWD, !FWD, 0, 0, 0, !FWD, 2'b00, 2'b00, 0);
    idle(); w_rd = 5'd6; w_reg_write = 1'b1; d_rs1 = 5'd6;
    step("raw_w", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Memory wait of three cycles, frozen branch acts on the release cycle.
    idle(); rst = 1'b1;
    step("rst_cnt", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    idle(); dmem_req = 1'b1;
    step("hold1", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    e_branch_taken = 1'b1; e_mem_read = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5;
    step("hold2_br", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    step("hold3_br", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    idle(); dmem_req = 1'b1; dmem_ready = 1'b1; e_branch_taken = 1'b1;
    step("release_br", 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    idle();
    step("hold_count", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Timeout: one RUN cycle then four MEM_WAIT cycles before ERROR.
    idle(); dmem_req = 1'b1;
    for (int i = 0; i < 5; i++)
      step("to_wait", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    idle();
    step("to_error", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
    e_branch_taken = 1'b1;
    step("err_br", 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
    idle(); rst = 1'b1;
    step("err_rst", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    idle();
    step("post_rst", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of consecutive MEM_WAIT cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports d_rs1 and d_rs2, input, 5 bits each: the source registers of the instruction in D.
REQ-006 SHALL have ports de_rs1 and de_rs2, input, 5 bits each: the source registers of the instruction in E.
REQ-007 SHALL have ports e_rd (5 bits), e_reg_write (1 bit) and e_mem_read (1 bit), all inputs: the E-stage destination, write enable and load flag.
REQ-008 SHALL have ports m_rd (5 bits) and m_reg_write (1 bit), inputs: the M-stage destination and write enable.
REQ-009 SHALL have ports w_rd (5 bits) and w_reg_write (1 bit), inputs: the W-stage destination and write enable.
REQ-010 SHALL have port e_branch_taken, input, 1 bit: a branch or jump resolved taken in E.
REQ-011 SHALL have ports dmem_req and dmem_ready, inputs, 1 bit each: the M-stage memory access handshake.
REQ-012 SHALL have outputs f_stall, stall, e_stall and m_stall, 1 bit each: hold the PC and the F/D, D/E and E/M registers respectively.
REQ-013 SHALL have outputs flush (1 bit, clears F/D) and e_flush (1 bit, inserts a bubble into D/E).
REQ-014 SHALL have outputs fwd_a and fwd_b, 2 bits each: the operand forward selects for de_rs1 and de_rs2.
REQ-015 SHALL have outputs mem_err (1 bit, sticky timeout flag) and stall_cycles (CNT_W bits, performance counter).

Function
REQ-016 SHALL implement the FSM states RUN, MEM_WAIT and ERROR.
REQ-017 SHALL define mem_hold = dmem_req & ~dmem_ready; in RUN, mem_hold SHALL move the FSM to MEM_WAIT on the next edge.
REQ-018 SHALL return from MEM_WAIT to RUN on the edge where dmem_ready=1.
REQ-019 SHALL, whenever mem_hold is set (in RUN or MEM_WAIT), assert f_stall, stall, e_stall and m_stall combinationally in the same cycle and force flush=0 and e_flush=0.
REQ-020 SHALL keep a wait counter that counts MEM_WAIT cycles; when the counter reaches TIMEOUT-1 with dmem_ready=0, the FSM SHALL go to ERROR.
REQ-021 SHALL, in ERROR, hold all four stall outputs at 1 and mem_err at 1 until rst.
REQ-022 SHALL detect load-use when e_mem_read & e_reg_write & e_rd!=0 & (e_rd==d_rs1 | e_rd==d_rs2).
REQ-023 SHALL, on load-use with no mem_hold, assert f_stall=1, stall=1 and e_flush=1 for exactly that cycle.
REQ-024 SHALL, when e_branch_taken=1 with no mem_hold, assert flush=1 and e_flush=1 and force f_stall=0 and stall=0; branch overrides load-use.
REQ-025 SHALL not act on a branch frozen in E during a memory hold until the release cycle, where REQ-024 applies.
REQ-026 SHALL set fwd_a to 2'b10 (from M) if m_reg_write & m_rd!=0 & m_rd==de_rs1; else to 2'b01 (from W) on the same test against w_rd; else to 2'b00; fwd_b likewise against de_rs2. M has priority over W.
REQ-027 SHALL increment stall_cycles on every cycle with f_stall=1, saturating at all-ones.
REQ-028 SHALL compute all stall, flush and fwd outputs combinationally from the inputs and state; zero added latency.

Reset
REQ-029 SHALL, with rst=1 at an edge, set state to RUN, the wait counter to 0, mem_err to 0 and stall_cycles to 0, including mid-MEM_WAIT and from ERROR.
REQ-030 SHALL, while rst=1, drive all stall and flush outputs to 0 and fwd_a and fwd_b to 2'b00.

Configuration
REQ-031 SHALL, with HAZARD_CTRL_FWD_EN defined, behave per REQ-026.
REQ-032 SHALL, without HAZARD_CTRL_FWD_EN, tie fwd_a and fwd_b to 2'b00 and treat any D-stage source matching a writing, nonzero e_rd or m_rd as load-use (REQ-023 response); W-stage matches SHALL not stall (register file is write-through).

Structure
REQ-033 SHALL take fwd_sel_t (FWD_NONE=00, FWD_W=01, FWD_M=10) and hz_state_t from the shared package hazard_ctrl_pkg.
REQ-034 SHALL place the forward-select logic in the combinational sub-module fwd_unit, instanced twice (operands a and b).

Verification
REQ-035 SHALL cover: e_mem_read=1, e_rd=5, d_rs1=5 -> one cycle of f_stall=stall=e_flush=1, then 0.
REQ-036 SHALL cover: m_rd=w_rd=7, both writing, de_rs2=7 -> fwd_b=10; with m_reg_write=0 -> fwd_b=01; with rd=0 -> 00.
REQ-037 SHALL cover: e_branch_taken=1 together with a load-use hazard -> flush=e_flush=1, f_stall=0.
REQ-038 SHALL cover: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> four stalls held 3 cycles, MEM_WAIT then RUN, stall_cycles=3.
REQ-039 SHALL cover: dmem_ready held 0 with TIMEOUT=4 -> ERROR and mem_err=1 after 4 cycles; rst then clears all state.
REQ-040 SHALL cover: without HAZARD_CTRL_FWD_EN, m_rd=3 writing and d_rs2=3 -> stall and e_flush asserted, fwd_b=00.
